alu_nibble_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 43 ++++
 rtl/alu_nibble_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU and the wide-operand sequencer.
package alu_pkg;

   localparam int unsigned NIBBLE = 4;
   localparam int unsigned CMD_W  = 2;

   typedef struct packed {
      logic             b_inv;
      logic             carry_disable;
      logic [CMD_W-1:0] cmd;
   } AluCtrl;

   localparam logic [CMD_W-1:0] ALU_SUM = 2'd0;
   localparam logic [CMD_W-1:0] ALU_AND = 2'd1;
   localparam logic [CMD_W-1:0] ALU_OR  = 2'd2;

endpackage

// File: rtl/alu.sv
// 4-bit combinational carry-lookahead ALU: SUM / AND / OR with optional B inversion.
module alu
   import alu_pkg::*;
(
   input  logic [NIBBLE-1:0] d1,
   input  logic [NIBBLE-1:0] d2,
   input  logic              carry_in,
   input  AluCtrl            ctrl,
   output logic [NIBBLE-1:0] res,
   output logic              carry_out
);

   logic [NIBBLE-1:0] bx;
   logic [NIBBLE-1:0] g;
   logic [NIBBLE-1:0] p;
   logic [NIBBLE:0]   c;

   always_comb begin
      bx   = ctrl.b_inv ? ~d2 : d2;
      g    = d1 & bx;
      p    = d1 ^ bx;
      c[0] = carry_in & ~ctrl.carry_disable;
      // flattened lookahead carries
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);

      res       = p;
      carry_out = 1'b0;
      case (ctrl.cmd)
         ALU_SUM: begin
            res       = p ^ c[NIBBLE-1:0];
            carry_out = c[NIBBLE];
         end
         ALU_AND: res = d1 & bx;
         ALU_OR:  res = d1 | bx;
         default: res = p;
      endcase
   end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Drives the 4-bit ALU one nibble per cycle (LSB first), chaining carries to build a WIDTH-bit result.
module alu_nibble_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   input  AluCtrl            req_ctrl,
   input  logic              req_carry_in,
   output logic [NIBBLE-1:0] alu_d1,
   output logic [NIBBLE-1:0] alu_d2,
   output logic              alu_carry_in,
   output AluCtrl            alu_ctrl,
   input  logic [NIBBLE-1:0] alu_res,
   input  logic              alu_carry_out,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  resp_res,
   output logic              resp_carry_out,
   output logic              resp_zero
);

   localparam int unsigned N     = WIDTH / NIBBLE;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   if (((WIDTH % NIBBLE) != 0) || (WIDTH < 8)) begin : g_width_check
      $error("alu_nibble_sequencer: WIDTH must be a multiple of 4 and at least 8");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic [IDX_W-1:0]         idx_nxt;
   logic                     last;
   logic [N-1:0][NIBBLE-1:0] a_q;
   logic [N-1:0][NIBBLE-1:0] b_q;
   logic [N-1:0][NIBBLE-1:0] result;
   logic [N-1:0][NIBBLE-1:0] result_nxt;

   // result with the current ALU nibble merged in
   always_comb begin
      idx_nxt         = idx + IDX_W'(1);
      last            = (idx == IDX_W'(N - 1));
      result_nxt      = result;
      result_nxt[idx] = alu_res;
   end

   assign resp_res = result;

   // alu_* drive is registered one nibble ahead so the ALU sees stable operands for a full cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         a_q            <= '0;
         b_q            <= '0;
         result         <= '0;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_carry_out <= 1'b0;
         resp_zero      <= 1'b1;
         alu_d1         <= '0;
         alu_d2         <= '0;
         alu_carry_in   <= 1'b0;
         alu_ctrl       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_q            <= req_a;
                  b_q            <= req_b;
                  idx            <= '0;
                  result         <= '0;
                  resp_carry_out <= 1'b0;
                  resp_zero      <= 1'b1;
                  req_ready      <= 1'b0;
                  alu_d1         <= req_a[NIBBLE-1:0];
                  alu_d2         <= req_b[NIBBLE-1:0];
                  alu_carry_in   <= req_carry_in;
                  alu_ctrl       <= req_ctrl;
                  state          <= RUN;
               end
            end
            RUN: begin
               result    <= result_nxt;
               resp_zero <= (result_nxt == '0);
               idx       <= idx_nxt;
               if (last) begin
                  resp_valid     <= 1'b1;
                  resp_carry_out <= (alu_ctrl.cmd == ALU_SUM) & alu_carry_out;
                  alu_d1         <= '0;
                  alu_d2         <= '0;
                  alu_carry_in   <= 1'b0;
                  alu_ctrl       <= '0;
                  state          <= DONE;
               end else begin
                  alu_d1       <= a_q[idx_nxt];
                  alu_d2       <= b_q[idx_nxt];
                  alu_carry_in <= alu_carry_out;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized self-checking bench: sequencer + ALU against a cycle-level arithmetic model.
module tb_alu_nibble_sequencer;
   import alu_pkg::*;

   localparam int unsigned W = 16;
   localparam int unsigned N = W / NIBBLE;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [W-1:0]      req_a = '0;
   logic [W-1:0]      req_b = '0;
   AluCtrl            req_ctrl = '0;
   logic              req_carry_in = 1'b0;
   logic [NIBBLE-1:0] alu_d1, alu_d2, alu_res;
   logic              alu_carry_in, alu_carry_out;
   AluCtrl            alu_ctrl;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [W-1:0]      resp_res;
   logic              resp_carry_out, resp_zero;

   always #5 clk = ~clk;

   alu_nibble_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_carry_in(req_carry_in),
      .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_carry_in(alu_carry_in), .alu_ctrl(alu_ctrl),
      .alu_res(alu_res), .alu_carry_out(alu_carry_out),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_res(resp_res), .resp_carry_out(resp_carry_out), .resp_zero(resp_zero)
   );

   alu u_alu (
      .d1(alu_d1), .d2(alu_d2), .carry_in(alu_carry_in), .ctrl(alu_ctrl),
      .res(alu_res), .carry_out(alu_carry_out)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic AluCtrl mk(input logic bi, input logic cd, input logic [1:0] cmd);
      AluCtrl c;
      c.b_inv         = bi;
      c.carry_disable = cd;
      c.cmd           = cmd;
      return c;
   endfunction

   // whole-word result {carry, res} from plain arithmetic
   function automatic logic [W:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input AluCtrl c, input logic cin);
      logic [W-1:0] bx;
      logic [W-1:0] r;
      logic [4:0]   s;
      logic         co;
      bx = c.b_inv ? ~b : b;
      r  = '0;
      co = 1'b0;
      if (c.cmd == ALU_AND) return {1'b0, a & bx};
      if (c.cmd == ALU_OR)  return {1'b0, a | bx};
      if (!c.carry_disable) return {1'b0, a} + {1'b0, bx} + (W+1)'(cin);
      for (int k = 0; k < int'(N); k++) begin
         s = {1'b0, a[NIBBLE*k +: NIBBLE]} + {1'b0, bx[NIBBLE*k +: NIBBLE]};
         r[NIBBLE*k +: NIBBLE] = s[3:0];
         co = s[4];
      end
      return {co, r};
   endfunction

   // carry presented to the ALU for nibble k
   function automatic logic model_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input AluCtrl c, input logic cin, input int k);
      logic [W-1:0] bx;
      logic [W:0]   mask;
      logic [W:0]   s;
      logic [4:0]   s5;
      if (k == 0) return cin;
      if (c.cmd != ALU_SUM) return 1'b0;
      bx = c.b_inv ? ~b : b;
      if (c.carry_disable) begin
         s5 = {1'b0, a[NIBBLE*(k-1) +: NIBBLE]} + {1'b0, bx[NIBBLE*(k-1) +: NIBBLE]};
         return s5[4];
      end
      mask = '0;
      for (int i = 0; i < NIBBLE*k; i++) mask[i] = 1'b1;
      s = ({1'b0, a} & mask) + ({1'b0, bx} & mask) + (W+1)'(cin);
      return s[NIBBLE*k];
   endfunction

   // transaction-level timing model: 0 idle, 1 running (m_wait cycles left), 2 holding response
   int           m_st = 0;
   int           m_wait = 0;
   logic [W-1:0] m_a = '0, m_b = '0;
   AluCtrl       m_ctrl = '0;
   logic         m_cin = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0;
      end else begin
         case (m_st)
            0: if (req_valid) begin
                  m_a <= req_a; m_b <= req_b; m_ctrl <= req_ctrl; m_cin <= req_carry_in;
                  m_wait <= int'(N); m_st <= 1;
               end
            1: begin
                  if (m_wait == 1) m_st <= 2;
                  m_wait <= m_wait - 1;
               end
            default: if (resp_ready) m_st <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic [W:0] e;
         int k;
         e = model_op(m_a, m_b, m_ctrl, m_cin);
         chk("req_ready", 32'(req_ready), 32'(m_st == 0));
         chk("resp_valid", 32'(resp_valid), 32'(m_st == 2));
         if (m_st == 1) begin
            k = int'(N) - m_wait;
            chk("alu_d1", 32'(alu_d1), 32'(m_a[NIBBLE*k +: NIBBLE]));
            chk("alu_d2", 32'(alu_d2), 32'(m_b[NIBBLE*k +: NIBBLE]));
            chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
            if (m_ctrl.cmd != 2'd3)
               chk("alu_carry_in", 32'(alu_carry_in), 32'(model_cin(m_a, m_b, m_ctrl, m_cin, k)));
         end else begin
            chk("alu_idle", 32'({alu_d1, alu_d2, alu_carry_in, alu_ctrl}), 32'd0);
         end
         if (m_st == 2 && m_ctrl.cmd != 2'd3) begin
            chk("resp_res", 32'(resp_res), 32'(e[W-1:0]));
            chk("resp_carry_out", 32'(resp_carry_out), 32'(e[W]));
            chk("resp_zero", 32'(resp_zero), 32'(e[W-1:0] == '0));
         end
      end
   end

   task automatic wait_ready();
      int guard = 0;
      while (!req_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) chk("resp_valid_wait", 32'(resp_valid), 32'd1);
   endtask

   task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input AluCtrl c,
                         input logic cin, input int rdy_delay,
                         output logic [W-1:0] r, output logic co, output logic z, output int lat);
      wait_ready();
      req_a = a; req_b = b; req_ctrl = c; req_carry_in = cin; req_valid = 1'b1;
      resp_ready = (rdy_delay == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = W'($urandom); req_b = W'($urandom);
      wait_resp(lat);
      r = resp_res; co = resp_carry_out; z = resp_zero;
      if (rdy_delay > 0) begin
         repeat (rdy_delay) @(posedge clk);
         #1;
         resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] r;
      logic         co, z;
      int           lat;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_res", 32'(resp_res), 32'd0);
      chk("rst_resp_zero", 32'(resp_zero), 32'd1);
      chk("rst_resp_carry", 32'(resp_carry_out), 32'd0);
      chk("rst_alu", 32'({alu_d1, alu_d2, alu_carry_in, alu_ctrl}), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      do_req(16'h1234, 16'h0FCD, mk(1'b0, 1'b0, ALU_SUM), 1'b0, 0, r, co, z, lat);
      chk("add_res", 32'(r), 32'h2201);
      chk("add_carry", 32'(co), 32'd0);
      chk("add_zero", 32'(z), 32'd0);
      chk("add_latency", 32'(lat), 32'd4);

      do_req(16'hFFFF, 16'h0001, mk(1'b0, 1'b0, ALU_SUM), 1'b0, 1, r, co, z, lat);
      chk("ovf_res", 32'(r), 32'h0000);
      chk("ovf_carry", 32'(co), 32'd1);
      chk("ovf_zero", 32'(z), 32'd1);

      do_req(16'h0005, 16'h0007, mk(1'b1, 1'b0, ALU_SUM), 1'b1, 0, r, co, z, lat);
      chk("sub_neg_res", 32'(r), 32'hFFFE);
      chk("sub_neg_carry", 32'(co), 32'd0);
      do_req(16'h0007, 16'h0005, mk(1'b1, 1'b0, ALU_SUM), 1'b1, 2, r, co, z, lat);
      chk("sub_pos_res", 32'(r), 32'h0002);
      chk("sub_pos_carry", 32'(co), 32'd1);

      do_req(16'hF0F0, 16'h3C3C, mk(1'b0, 1'b1, ALU_AND), 1'b0, 0, r, co, z, lat);
      chk("and_res", 32'(r), 32'h3030);
      chk("and_carry", 32'(co), 32'd0);

      do_req(16'h1234, 16'h4321, mk(1'b0, 1'b0, 2'd3), 1'b0, 0, r, co, z, lat);
      chk("cmd3_latency", 32'(lat), 32'd4);

      // backpressure with an ignored request pulse
      wait_ready();
      req_a = 16'h00FF; req_b = 16'h0001; req_ctrl = mk(1'b0, 1'b0, ALU_SUM);
      req_carry_in = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_resp(lat);
      for (int i = 0; i < 5; i++) begin
         chk("bp_res", 32'(resp_res), 32'h0100);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         req_valid = (i == 2);
         req_a = 16'hAAAA;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("bp_release_ready", 32'(req_ready), 32'd1);
      chk("bp_release_valid", 32'(resp_valid), 32'd0);

      // reset while idx = 2
      wait_ready();
      req_a = 16'h5555; req_b = 16'h1111; req_ctrl = mk(1'b0, 1'b0, ALU_SUM); req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_res", 32'(resp_res), 32'd0);
      chk("mid_rst_zero", 32'(resp_zero), 32'd1);
      chk("mid_rst_alu", 32'({alu_d1, alu_d2, alu_carry_in, alu_ctrl}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
      end
      do_req(16'h0F0F, 16'h0101, mk(1'b0, 1'b0, ALU_SUM), 1'b0, 0, r, co, z, lat);
      chk("post_rst_res", 32'(r), 32'h1010);
      chk("post_rst_latency", 32'(lat), 32'd4);

      for (int t = 0; t < 80; t++) begin
         do_req(W'($urandom), W'($urandom),
                mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r, co, z, lat);
         chk("rand_latency", 32'(lat), 32'(N));
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
